// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and parameter checks for the scanning channel mux
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int channels, input int sel_w, input int scan_div);
    return (channels >= 2) && (channels <= 16) && (clog2(channels) <= sel_w) && (scan_div >= 1);
  endfunction

endpackage

// File: rtl/scan_counter_n.sv
// rtl/scan_counter_n.sv - channel index and dwell divider; manual load or round-robin scan with wrap pulse
module scan_counter_n
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int DIV_W = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   NCH      = (SEL_W + 1)'(CHANNELS);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      div  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (enable) begin
        if (mode == MODE_SCAN) begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (idx == IDX_LAST) begin
              idx  <= '0;
              wrap <= 1'b1;
            end else begin
              idx <= idx + SEL_W'(1);
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end else begin
          // out-of-range manual selects are ignored rather than aliased
          div <= '0;
          if ({1'b0, sel} < NCH) idx <= sel;
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual/scan select and one-hot strobe
// Optional MUX_SCAN_BLANK_EN: blank the strobe for the first cycle after each channel change.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic [CHANNELS*BITS-1:0] D,
  input  logic                     MODE,
  input  logic [SEL_W-1:0]         SEL,
  input  logic                     ENABLE,
  output logic [BITS-1:0]          MUX_OUT,
  output logic [SEL_W-1:0]         CH_OUT,
  output logic [CHANNELS-1:0]      CH_ONEHOT,
  output logic                     WRAP
);

  if (!params_ok(CHANNELS, SEL_W, SCAN_DIV)) begin : g_bad_params
    $error("mux_scan_n: illegal CHANNELS/SEL_W/SCAN_DIV combination");
  end

  logic [SEL_W-1:0]    idx;
  logic [BITS-1:0]     data_next;
  logic [CHANNELS-1:0] onehot_next;
  logic [CHANNELS-1:0] strobe_next;

  scan_counter_n #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_counter (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .enable (ENABLE),
    .mode   (MODE),
    .sel    (SEL),
    .idx    (idx),
    .wrap   (WRAP)
  );

  always_comb begin
    data_next   = '0;
    onehot_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        data_next      = D[k*BITS +: BITS];
        onehot_next[k] = 1'b1;
      end
    end
  end

`ifdef MUX_SCAN_BLANK_EN
  // a channel change shows up as idx differing from the channel currently displayed
  assign strobe_next = (idx != CH_OUT) ? '0 : onehot_next;
`else
  assign strobe_next = onehot_next;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      MUX_OUT   <= '0;
      CH_OUT    <= '0;
      CH_ONEHOT <= '0;
    end else if (ENABLE) begin
      MUX_OUT   <= data_next;
      CH_OUT    <= idx;
      CH_ONEHOT <= strobe_next;
    end else begin
      CH_ONEHOT <= '0;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed self-checking bench for mux_scan_n (4ch x 4b, SCAN_DIV=3; 5ch side instance)
module tb_mux_scan_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] d;
  logic [19:0] d5;
  logic        mode;
  logic [1:0]  sel;
  logic [2:0]  sel5;
  logic        enable;
  logic [3:0]  mux_out;
  logic [1:0]  ch_out;
  logic [3:0]  ch_onehot;
  logic        wrap;
  logic [3:0]  mux_out5;
  logic [2:0]  ch_out5;
  logic [4:0]  ch_onehot5;
  logic        wrap5;

  int total;
  int bad;
  int prev_ch;

  mux_scan_n #(.BITS(4), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(3)) u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .D(d), .MODE(mode), .SEL(sel), .ENABLE(enable),
    .MUX_OUT(mux_out), .CH_OUT(ch_out), .CH_ONEHOT(ch_onehot), .WRAP(wrap)
  );

  mux_scan_n #(.BITS(4), .CHANNELS(5), .SEL_W(3), .SCAN_DIV(3)) u_dut5 (
    .CLOCK(clk), .RESET_N(rst_n), .D(d5), .MODE(1'b0), .SEL(sel5), .ENABLE(enable),
    .MUX_OUT(mux_out5), .CH_OUT(ch_out5), .CH_ONEHOT(ch_onehot5), .WRAP(wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_oh(input int ch, input int prev);
    logic [3:0] one;
    one = 4'b0001;
`ifdef MUX_SCAN_BLANK_EN
    if (ch != prev) return 4'b0000;
`endif
    return one << ch;
  endfunction

  // channel k carries value k, so data and index share one expectation
  task automatic chk_out(input string tag, input int ch);
    chk({tag, ".mux"}, 32'(mux_out), 32'(ch));
    chk({tag, ".ch"}, 32'(ch_out), 32'(ch));
    chk({tag, ".oh"}, 32'(ch_onehot), 32'(exp_oh(ch, prev_ch)));
    prev_ch = ch;
  endtask

  int scan_exp [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int sel_seq  [5]  = '{0, 1, 2, 3, 3};

  initial begin
    total   = 0;
    bad     = 0;
    prev_ch = 0;
    d       = {4'd3, 4'd2, 4'd1, 4'd0};
    d5      = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    mode    = 1'b0;
    sel     = 2'd0;
    sel5    = 3'd0;
    enable  = 1'b1;
    rst_n   = 1'b0;

    #1;
    chk("reset.mux", 32'(mux_out), 32'd0);
    chk("reset.oh", 32'(ch_onehot), 32'd0);
    chk("reset.wrap", 32'(wrap), 32'd0);
    tick();
    rst_n = 1'b1;
    sel   = 2'd2;
    tick();
    chk_out("pre.c1", 0);
    tick();
    chk_out("pre.c2", 2);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.mux", 32'(mux_out), 32'd0);
    chk("async.ch", 32'(ch_out), 32'd0);
    chk("async.oh", 32'(ch_onehot), 32'd0);
    chk("async.wrap", 32'(wrap), 32'd0);
    prev_ch = 0;
    tick();
    rst_n = 1'b1;
    sel   = 2'd0;
    tick();
    chk_out("release", 0);

    // manual select, two-cycle latency from SEL
    for (int i = 0; i < 5; i++) begin
      sel = 2'(sel_seq[i]);
      tick();
      if (i > 0) chk_out($sformatf("manual%0d", i), sel_seq[i-1]);
    end
    tick();
    chk_out("manual5", 3);

    // out-of-range select on the 5-channel instance
    sel5 = 3'd3;
    tick();
    tick();
    chk("sel5.in", 32'(mux_out5), 32'd3);
    sel5 = 3'd5;
    tick();
    tick();
    chk("sel5.ign5.mux", 32'(mux_out5), 32'd3);
    chk("sel5.ign5.ch", 32'(ch_out5), 32'd3);
    sel5 = 3'd7;
    tick();
    tick();
    chk("sel5.ign7.oh", 32'(ch_onehot5), 32'b01000);

    // scan from IDX=0
    sel = 2'd0;
    tick();
    tick();
    chk_out("scan.start", 0);
    mode = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      chk_out($sformatf("scan%0d", n), scan_exp[n-1]);
      chk($sformatf("scan%0d.wrap", n), 32'(wrap), (n == 12) ? 32'd1 : 32'd0);
    end
    tick();
    chk_out("scan14", 0);

    // freeze while disabled
    enable = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("dis%0d.mux", n), 32'(mux_out), 32'd0);
      chk($sformatf("dis%0d.ch", n), 32'(ch_out), 32'd0);
      chk($sformatf("dis%0d.oh", n), 32'(ch_onehot), 32'd0);
      chk($sformatf("dis%0d.wrap", n), 32'(wrap), 32'd0);
    end
    enable = 1'b1;
    tick();
    chk_out("resume0", 0);
    tick();
    chk_out("resume1", 1);
    tick();
    chk_out("resume2", 1);
    tick();
    chk_out("resume3", 1);
    tick();
    chk_out("resume4", 2);

    // scan -> manual -> scan
    mode = 1'b0;
    sel  = 2'd0;
    tick();
    chk_out("toman1", 2);
    chk("toman1.wrap", 32'(wrap), 32'd0);
    tick();
    chk_out("toman2", 0);
    chk("toman2.wrap", 32'(wrap), 32'd0);
    mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_out($sformatf("rescan%0d", n), (n == 3) ? 1 : 0);
      chk($sformatf("rescan%0d.wrap", n), 32'(wrap), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
